prog_load_ctrl: RTL and testbench



---
 rtl/prog_load_ctrl_pkg.sv | 14 +
 rtl/prog_byte_asm.sv | 29 ++
 rtl/prog_load_ctrl.sv | 125 ++++++++++++
 tb/tb_prog_load_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/prog_load_ctrl_pkg.sv
// prog_load_ctrl_pkg: shared FSM states and frame geometry for the program loader.
package prog_load_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_HDR,
    S_LOAD,
    S_CKSUM,
    S_SWITCH
  } state_e;
  localparam int HDR_BYTES   = 6;
  localparam int WORD_BYTES  = 4;
  localparam int CKSUM_BYTES = 1;
endpackage

// File: rtl/prog_byte_asm.sv
// prog_byte_asm: packs big-endian bytes into 32-bit words, word_valid the cycle after the 4th byte.
module prog_byte_asm
  import prog_load_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic [1:0]  cnt_q;
  logic [31:0] sr_q;
  logic        vld_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= byte_valid_i && cnt_q == 2'(WORD_BYTES - 1);
      sr_q  <= byte_valid_i ? {sr_q[23:0], byte_i} : sr_q;
      cnt_q <= cnt_q + 2'(byte_valid_i);
    end
  end
  assign word_valid_o = vld_q;
  assign word_o       = sr_q;
endmodule

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: SPART program download into imem, then redirect fetch via switch_program.
// Define PROG_CKSUM_EN to require a trailing XOR checksum byte after the data.
module prog_load_ctrl
  import prog_load_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DRAIN_CYC   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              stall_pc,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              switch_program,
  output logic [31:0]       SPART_pc,
  output logic              busy,
  output logic              load_err
);
  localparam int CW = $clog2(TIMEOUT_CYC + DRAIN_CYC + 1);
`ifdef PROG_CKSUM_EN
  localparam state_e S_TAIL = S_CKSUM;
`else
  localparam state_e S_TAIL = S_SWITCH;
`endif
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  hdr_q, hdr_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] n_q, n_d, widx_q, widx_d;
  logic        err_q, abort;
  logic        acc, tmo, last_wr, word_valid;
  logic [31:0] word;
  logic [15:0] n_nxt;
  logic        waiting;
`ifdef PROG_CKSUM_EN
  logic [7:0]  ck_q, ck_d;
`endif
  assign acc     = rx_valid && rx_ready;
  assign n_nxt   = {n_q[7:0], rx_data};
  assign last_wr = state_q == S_LOAD && word_valid && widx_q == n_q - 16'd1;
  assign waiting = state_q == S_HDR || state_q == S_LOAD || state_q == S_CKSUM;
  assign tmo     = waiting && !acc && cnt_q == CW'(TIMEOUT_CYC - 1);
  prog_byte_asm u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (state_q != S_LOAD),
    .byte_valid_i (acc && state_q == S_LOAD),
    .byte_i       (rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    abort   = tmo;
    case (state_q)
      S_IDLE:   state_d = rx_valid ? S_DRAIN : S_IDLE;
      S_DRAIN:  state_d = cnt_q == CW'(DRAIN_CYC - 1) ? S_HDR : S_DRAIN;
      S_HDR:    state_d = tmo ? S_IDLE :
                          (acc && hdr_q == 3'(HDR_BYTES - 1)) ? (n_nxt == 16'd0 ? S_TAIL : S_LOAD) : S_HDR;
      S_LOAD:   state_d = tmo ? S_IDLE : last_wr ? S_TAIL : S_LOAD;
`ifdef PROG_CKSUM_EN
      S_CKSUM: begin
        abort   = tmo || (acc && rx_data != ck_q);
        state_d = abort ? S_IDLE : acc ? S_SWITCH : S_CKSUM;
      end
`endif
      S_SWITCH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    cnt_d  = (state_d != state_q || acc || state_q == S_IDLE) ? '0 : cnt_q + CW'(1);
    hdr_d  = state_q == S_HDR ? hdr_q + 3'(acc) : '0;
    widx_d = state_q == S_LOAD ? widx_q + 16'(word_valid) : '0;
    pc_d   = (state_q == S_HDR && acc && hdr_q < 3'(WORD_BYTES)) ? {pc_q[23:0], rx_data} : pc_q;
    n_d    = (state_q == S_HDR && acc && hdr_q >= 3'(WORD_BYTES)) ? n_nxt : n_q;
`ifdef PROG_CKSUM_EN
    ck_d   = state_q == S_IDLE ? 8'd0 : acc ? ck_q ^ rx_data : ck_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      hdr_q  <= '0;
      widx_q <= '0;
      pc_q   <= '0;
      n_q    <= '0;
      err_q  <= 1'b0;
`ifdef PROG_CKSUM_EN
      ck_q   <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      hdr_q  <= hdr_d;
      widx_q <= widx_d;
      pc_q   <= pc_d;
      n_q    <= n_d;
      err_q  <= abort;
`ifdef PROG_CKSUM_EN
      ck_q   <= ck_d;
`endif
    end
  end
  // The final word's write cycle accepts no byte so a trailing byte lands in CKSUM.
  always_comb begin
    rx_ready       = state_q == S_HDR || (state_q == S_LOAD && !last_wr) || state_q == S_CKSUM;
    stall_pc       = state_q != S_IDLE;
    busy           = state_q != S_IDLE;
    im_we          = state_q == S_LOAD && word_valid;
    im_waddr       = pc_q[ADDR_W-1:0] + ADDR_W'(widx_q);
    im_wdata       = word;
    switch_program = state_q == S_SWITCH;
    SPART_pc       = state_q == S_SWITCH ? pc_q : '0;
    load_err       = err_q;
  end
endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl: directed and random frames checked against a frame-level reference model.
module tb_prog_load_ctrl;
  localparam int AW = 10;
  localparam int DC = 4;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, stall_pc, im_we, switch_program, busy, load_err;
  logic [AW-1:0] im_waddr;
  logic [31:0] im_wdata, SPART_pc;
  int checks = 0, errors = 0;
  logic [AW-1:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] mem[1<<AW];
  int sw_n = 0, err_n = 0, ovl_n = 0, drop_n = 0, drop_sw_n = 0, sw_nostall = 0;
  logic [31:0] sw_pc = '0;
  logic prev_stall = 1'b0, prev_sw = 1'b0;
  always #5 clk = ~clk;
  prog_load_ctrl #(.ADDR_W(AW), .DRAIN_CYC(DC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .stall_pc(stall_pc), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .switch_program(switch_program), .SPART_pc(SPART_pc), .busy(busy), .load_err(load_err)
  );
  always @(negedge clk) begin
    if (im_we) begin
      wa_q.push_back(im_waddr);
      wd_q.push_back(im_wdata);
      mem[im_waddr] = im_wdata;
    end
    if (switch_program) begin
      sw_n++;
      sw_pc = SPART_pc;
      if (!stall_pc) sw_nostall++;
    end
    if (load_err) err_n++;
    if (im_we && switch_program) ovl_n++;
    if (prev_stall && !stall_pc) begin
      drop_n++;
      if (prev_sw) drop_sw_n++;
    end
    prev_stall = stall_pc;
    prev_sw = switch_program;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_valid = 1'b1;
    rx_data = b;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    check("byte_accepted", {31'b0, ok}, 32'd1);
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 64 && busy; k++) begin
      @(posedge clk);
      #1;
    end
    check("back_to_idle", {31'b0, busy}, 32'd0);
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, {31'b0, stall_pc}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_we"}, {31'b0, im_we}, 0);
    check({tag, "_sw"}, {31'b0, switch_program}, 0);
    check({tag, "_rdy"}, {31'b0, rx_ready}, 0);
    check({tag, "_err"}, {31'b0, load_err}, 0);
    check({tag, "_spc"}, SPART_pc, 0);
    check({tag, "_waddr"}, {22'b0, im_waddr}, 0);
    check({tag, "_wdata"}, im_wdata, 0);
  endtask
  task automatic build(input logic [31:0] pc, input int n, input logic [31:0] w0, input logic [31:0] w1,
                       output logic [7:0] fb[$], output logic [31:0] ws[$]);
    fb = {pc[31:24], pc[23:16], pc[15:8], pc[7:0], 8'(n >> 8), 8'(n)};
    ws = {};
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = i == 0 ? w0 : i == 1 ? w1 : $urandom;
      ws.push_back(w);
      fb.push_back(w[31:24]); fb.push_back(w[23:16]); fb.push_back(w[15:8]); fb.push_back(w[7:0]);
    end
  endtask
  task automatic run_frame(input logic [31:0] pc, input int n, input logic [31:0] w0, input logic [31:0] w1,
                           input bit corrupt);
    logic [7:0] fb[$];
    logic [31:0] ws[$];
    logic [7:0] x;
    int wb, s0, e0, d0, ds0;
    bit good;
    wb = wa_q.size(); s0 = sw_n; e0 = err_n; d0 = drop_n; ds0 = drop_sw_n;
    good = !corrupt;
    build(pc, n, w0, w1, fb, ws);
    x = 8'h00;
    foreach (fb[i]) x ^= fb[i];
`ifdef PROG_CKSUM_EN
    fb.push_back(corrupt ? ~x : x);
`endif
    foreach (fb[i]) begin
      send_byte(fb[i]);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("write_count", wa_q.size() - wb, n);
    for (int i = 0; i < n && wb + i < wa_q.size(); i++) begin
      check("write_addr", {22'b0, wa_q[wb+i]}, (pc + 32'(i)) % 32'(1 << AW));
      check("write_data", wd_q[wb+i], ws[i]);
    end
    check("switch_count", sw_n - s0, good ? 1 : 0);
    check("err_count", err_n - e0, good ? 0 : 1);
    check("stall_drops", drop_n - d0, 1);
    check("stall_drop_after_switch", drop_sw_n - ds0, good ? 1 : 0);
    if (good) check("spart_pc", sw_pc, pc);
  endtask
  initial begin
    logic [7:0] fb[$];
    logic [31:0] ws[$];
    logic [31:0] pc;
    int wb, s0, e0, k;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_quiet("reset");
    run_frame(32'h0000_0010, 2, 32'h1122_3344, 32'hAABB_CCDD, 1'b0);
    run_frame(32'h0000_0020, 0, 32'h0, 32'h0, 1'b0);
    run_frame(32'h0000_03FF, 2, $urandom, $urandom, 1'b0);
    for (int r = 0; r < 4; r++) run_frame($urandom, $urandom_range(1, 6), $urandom, $urandom, 1'b0);
`ifdef PROG_CKSUM_EN
    run_frame(32'h0000_0010, 2, 32'h1122_3344, 32'hAABB_CCDD, 1'b1);
`endif
    // timeout after three data bytes of the first word
    wb = wa_q.size(); s0 = sw_n; e0 = err_n;
    build(32'h0000_0040, 2, $urandom, $urandom, fb, ws);
    for (int i = 0; i < 9; i++) send_byte(fb[i]);
    for (k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (load_err) break;
    end
    check("timeout_cycles", k, TO);
    check("timeout_stall", {31'b0, stall_pc}, 0);
    check("timeout_busy", {31'b0, busy}, 0);
    @(posedge clk);
    #1;
    check("timeout_pulse_len", {31'b0, load_err}, 0);
    check("timeout_writes", wa_q.size() - wb, 0);
    check("timeout_switch", sw_n - s0, 0);
    check("timeout_errs", err_n - e0, 1);
    run_frame($urandom, 3, $urandom, $urandom, 1'b0);
    // reset after the first word has been written
    pc = $urandom;
    wb = wa_q.size(); s0 = sw_n;
    build(pc, 3, $urandom, $urandom, fb, ws);
    for (int i = 0; i < 10; i++) send_byte(fb[i]);
    for (int j = 0; j < 8 && wa_q.size() == wb; j++) begin
      @(posedge clk);
      #1;
    end
    check("midload_first_write", wa_q.size() - wb, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_quiet("midload_reset");
    check("midload_mem", mem[pc % 32'(1 << AW)], ws[0]);
    repeat (4) @(posedge clk);
    #1;
    check("midload_switch", sw_n - s0, 0);
    run_frame(32'h0000_0010, 2, 32'h1122_3344, 32'hAABB_CCDD, 1'b0);
    check("we_switch_overlap", ovl_n, 0);
    check("switch_without_stall", sw_nostall, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
